draw_scheduler: RTL and testbench
=================================

# draw_scheduler

Shares the single VGA adapter write port (160x120, 3-bit colour) between three sprite/overlay drawing clients and a built-in full-screen clear engine. It sits between the game control FSM's drawing units (pet sprite, stat bars, status icons) and the VGA adapter. It owns the adapter's x, y, colour and plot inputs. Clear requests take priority at arbitration time. Clients are served round-robin, and a granted client is never preempted.

## Interface
- X_SCREEN_PIXELS, 8'd160, horizontal resolution; x counter range 0..X_SCREEN_PIXELS-1
- Y_SCREEN_PIXELS, 7'd120, vertical resolution; y counter range 0..Y_SCREEN_PIXELS-1
- Clock and reset: one clock; reset is synchronous and active-high.
- clk  in  1  system clock (50 MHz board clock)
- reset  in  1  synchronous, active-high reset
- clear_req  in  1  request a black fill of the whole screen; single-cycle pulse or level
- req  in  3  per-client draw request, bit i = client i; level, held until done
- c_x  in  24  client x coordinates, client i at [8i+7:8i]
- c_y  in  21  client y coordinates, client i at [7i+6:7i]
- c_colour  in  9  client colours, client i at [3i+2:3i]
- c_plot  in  3  per-client pixel write strobe
- c_done  in  3  per-client end-of-drawing pulse
- gnt  out  3  one-hot grant; all zero when no client owns the port
- x  out  8  VGA adapter x
- y  out  7  VGA adapter y
- colour  out  3  VGA adapter colour
- plot  out  1  VGA adapter write enable
- clear_busy  out  1  high while the clear engine owns the port
- clear_done  out  1  one-cycle pulse after the last clear pixel is written

## Operation
- States: IDLE, CLEAR, GRANT.
- clear_pending flag
  - Set on any cycle with clear_req=1.
  - Cleared on entry to CLEAR.
  - A clear_req while in CLEAR re-arms the flag; the screen is cleared again afterwards.
- Round-robin pointer last[1:0]
  - Holds the index of the most recently granted client.
  - Reset value is 2, so client 0 has first priority.
- IDLE
  - If clear_pending or clear_req: go to CLEAR with xc=0, yc=0.
  - Else if req is nonzero: pick the first requesting index after last, in order last+1, last+2, last (mod 3). Go to GRANT with gnt set to that index.
  - Else: remain in IDLE.
- CLEAR
  - Raster order, x fastest: xc increments 0..159, then wraps to 0 and yc increments.
  - Every cycle: plot=1, colour=0, x=xc, y=yc, clear_busy=1.
  - After pixel (159,119): clear_done=1 for one cycle and return to IDLE.
  - Total 19200 plot cycles.
- GRANT(i)
  - gnt[i]=1.
  - x, y, colour and plot are registered copies of client i's fields.
  - plot is forced to 0 when c_x_i>=160 or c_y_i>=120 (clipping).
  - Exit to IDLE when c_done[i]=1 or req[i]=0; set last=i on exit.
  - Other clients' req, c_plot and c_done are ignored.
- No preemption: a clear_req arriving during GRANT is only recorded in clear_pending.
- Reset mid-operation: reset takes effect from any state, including mid-CLEAR and mid-GRANT, and returns the block to reset values on the next edge. It clears clear_pending and abandons the partial clear.
- Reset values: state=IDLE, gnt=0, x=0, y=0, colour=0, plot=0, clear_busy=0, clear_done=0, clear_pending=0, last=2, xc=0, yc=0.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Grant latency: if req[i] is high at edge t while in IDLE, gnt[i] is high after edge t.
- Data latency: a client pixel presented at edge t (with gnt[i] high) appears on x/y/colour/plot after edge t+1.
  - Clients may stream one pixel per cycle while granted.
- Grant release:
  - c_done[i] sampled at edge t drops gnt after edge t.
  - plot is 0 after edge t, so the done-cycle pixel is not written. Clients assert c_done only after their last c_plot.
- Dead cycle: at least one IDLE cycle between consecutive grants, and between a grant and a clear.
- Clear latency: clear_req sampled in IDLE at edge t gives clear_busy=1 and the first pixel (0,0) after edge t.
  - Last pixel (159,119) is written after edge t+19199.
  - clear_done pulses and clear_busy drops after edge t+19200.
- Simultaneous events in IDLE: clear beats all clients; among clients, round-robin order decides.

## Test plan
- Reset, then clear_req pulse:
  - Exactly 19200 plot cycles, covering (0,0) through (159,119) in raster order, all colour=0.
  - clear_done is a single pulse one cycle after pixel (159,119).
- req=3'b111 held, each client does 4 plots then c_done:
  - Grant order is 0,1,2,0, with one idle cycle between grants.
  - Each pixel appears on the output one cycle after it is presented.
- Client 1 granted, clear_req pulse mid-stream:
  - Client 1 completes uninterrupted.
  - CLEAR starts after one IDLE cycle.
  - Client 0's pending req is served only after clear_done.
- Client 2 presents (160,5,colour 7) then (159,119,colour 5):
  - First pixel: plot stays 0.
  - Second pixel: x=159, y=119, colour=5, plot=1.
- Assert reset at clear pixel (50,30):
  - Next cycle all outputs are 0 and state is IDLE.
  - The next req[0] is granted, confirming last was restored to 2.
- Client 0 granted drops req[0] without c_done:
  - gnt drops next cycle.
  - A subsequent request from both 0 and 1 grants client 1 first.

Source files
------------

// File: rtl/draw_scheduler.sv
// draw_scheduler: arbitrates the VGA write port between three drawing clients and a full-screen clear engine.
module draw_scheduler #(
  parameter logic [7:0] X_SCREEN_PIXELS = 8'd160,
  parameter logic [6:0] Y_SCREEN_PIXELS = 7'd120
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear_req,
  input  logic [2:0]  req,
  input  logic [23:0] c_x,
  input  logic [20:0] c_y,
  input  logic [8:0]  c_colour,
  input  logic [2:0]  c_plot,
  input  logic [2:0]  c_done,
  output logic [2:0]  gnt,
  output logic [7:0]  x,
  output logic [6:0]  y,
  output logic [2:0]  colour,
  output logic        plot,
  output logic        clear_busy,
  output logic        clear_done
);
  typedef enum logic [1:0] {IDLE, CLEAR, GRANT} state_t;
  state_t state_q, state_d;
  logic [2:0] gnt_q, gnt_d, colour_q, colour_d, ccol;
  logic [7:0] x_q, x_d, xc_q, xc_d, cx;
  logic [6:0] y_q, y_d, yc_q, yc_d, cy;
  logic plot_q, plot_d, busy_q, busy_d, done_q, done_d, pend_q, pend_d;
  logic [1:0] last_q, last_d, idx_q, idx_d, c1, c2, pick;
  function automatic logic [1:0] inc3(input logic [1:0] a);
    return (a == 2'd2) ? 2'd0 : a + 2'd1;
  endfunction
  always_comb begin
    c1 = inc3(last_q);
    c2 = inc3(c1);
    pick = req[c1] ? c1 : req[c2] ? c2 : last_q;
    cx = (idx_q == 2'd0) ? c_x[7:0] : (idx_q == 2'd1) ? c_x[15:8] : c_x[23:16];
    cy = (idx_q == 2'd0) ? c_y[6:0] : (idx_q == 2'd1) ? c_y[13:7] : c_y[20:14];
    ccol = (idx_q == 2'd0) ? c_colour[2:0] : (idx_q == 2'd1) ? c_colour[5:3] : c_colour[8:6];
    state_d = state_q;
    gnt_d = gnt_q;
    x_d = x_q;
    y_d = y_q;
    colour_d = colour_q;
    plot_d = plot_q;
    busy_d = busy_q;
    done_d = 1'b0;
    pend_d = pend_q | clear_req;
    last_d = last_q;
    idx_d = idx_q;
    xc_d = xc_q;
    yc_d = yc_q;
    case (state_q)
      IDLE: begin
        gnt_d = 3'b000;
        x_d = 8'd0;
        y_d = 7'd0;
        colour_d = 3'd0;
        plot_d = 1'b0;
        busy_d = 1'b0;
        if (pend_q || clear_req) begin
          state_d = CLEAR;
          pend_d = 1'b0;
          xc_d = 8'd0;
          yc_d = 7'd0;
          plot_d = 1'b1;
          busy_d = 1'b1;
        end else if (|req) begin
          state_d = GRANT;
          idx_d = pick;
          gnt_d = 3'b001 << pick;
        end
      end
      CLEAR: begin
        if (xc_q == X_SCREEN_PIXELS - 8'd1 && yc_q == Y_SCREEN_PIXELS - 7'd1) begin
          state_d = IDLE;
          done_d = 1'b1;
          busy_d = 1'b0;
          plot_d = 1'b0;
          xc_d = 8'd0;
          yc_d = 7'd0;
          x_d = 8'd0;
          y_d = 7'd0;
        end else begin
          xc_d = (xc_q == X_SCREEN_PIXELS - 8'd1) ? 8'd0 : xc_q + 8'd1;
          yc_d = (xc_q == X_SCREEN_PIXELS - 8'd1) ? yc_q + 7'd1 : yc_q;
          x_d = xc_d;
          y_d = yc_d;
          colour_d = 3'd0;
          plot_d = 1'b1;
          busy_d = 1'b1;
        end
      end
      GRANT: begin
        if (c_done[idx_q] || !req[idx_q]) begin
          state_d = IDLE;
          gnt_d = 3'b000;
          plot_d = 1'b0;
          last_d = idx_q;
        end else begin
          x_d = cx;
          y_d = cy;
          colour_d = ccol;
          plot_d = c_plot[idx_q] && (cx < X_SCREEN_PIXELS) && (cy < Y_SCREEN_PIXELS);
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      gnt_q <= 3'b000;
      x_q <= 8'd0;
      y_q <= 7'd0;
      colour_q <= 3'd0;
      plot_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      pend_q <= 1'b0;
      last_q <= 2'd2;
      idx_q <= 2'd0;
      xc_q <= 8'd0;
      yc_q <= 7'd0;
    end else begin
      state_q <= state_d;
      gnt_q <= gnt_d;
      x_q <= x_d;
      y_q <= y_d;
      colour_q <= colour_d;
      plot_q <= plot_d;
      busy_q <= busy_d;
      done_q <= done_d;
      pend_q <= pend_d;
      last_q <= last_d;
      idx_q <= idx_d;
      xc_q <= xc_d;
      yc_q <= yc_d;
    end
  end
  assign gnt = gnt_q;
  assign x = x_q;
  assign y = y_q;
  assign colour = colour_q;
  assign plot = plot_q;
  assign clear_busy = busy_q;
  assign clear_done = done_q;
endmodule

// File: tb/tb_draw_scheduler.sv
// tb_draw_scheduler: directed checks of clear engine, round-robin grants, clipping and reset for draw_scheduler.
module tb_draw_scheduler;
  logic clk = 1'b0, reset = 1'b1, clear_req = 1'b0;
  logic [2:0] req = '0, c_plot = '0, c_done = '0;
  logic [23:0] c_x = '0;
  logic [20:0] c_y = '0;
  logic [8:0] c_colour = '0;
  logic [2:0] gnt, colour;
  logic [7:0] x;
  logic [6:0] y;
  logic plot, clear_busy, clear_done;
  int n_chk = 0, n_fail = 0;
  draw_scheduler dut (.clk(clk), .reset(reset), .clear_req(clear_req), .req(req), .c_x(c_x), .c_y(c_y),
    .c_colour(c_colour), .c_plot(c_plot), .c_done(c_done), .gnt(gnt), .x(x), .y(y), .colour(colour),
    .plot(plot), .clear_busy(clear_busy), .clear_done(clear_done));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] outs();
    return {8'b0, gnt, x, y, colour, plot, clear_busy, clear_done};
  endfunction
  function automatic logic [31:0] ev(input logic [2:0] g, input logic [7:0] ex, input logic [6:0] ey,
                                     input logic [2:0] ec, input logic p, input logic b, input logic d);
    return {8'b0, g, ex, ey, ec, p, b, d};
  endfunction
  task automatic serve(input int i);
    tick();
    chk("rr_gnt", 32'(gnt), 32'(3'b001 << i));
    for (int p = 0; p < 4; p++) begin
      for (int j = 0; j < 3; j++) begin
        c_x[8*j +: 8] = 8'(20 * j + p + 1);
        c_y[7*j +: 7] = 7'(10 * j + p + 2);
        c_colour[3*j +: 3] = 3'(j + p + 1);
      end
      c_plot = 3'b111;
      tick();
      chk("rr_pix", outs(), ev(3'(1 << i), 8'(20 * i + p + 1), 7'(10 * i + p + 2), 3'(i + p + 1), 1'b1, 1'b0, 1'b0));
    end
    c_plot = '0;
    c_done = 3'(1 << i);
    tick();
    chk("rr_rel", 32'({gnt, plot, clear_busy}), 32'd0);
    c_done = '0;
  endtask
  initial begin
    int plots;
    tick();
    tick();
    reset = 1'b0;
    chk("reset_outs", outs(), 32'd0);
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    plots = 0;
    for (int k = 0; k < 19200; k++) begin
      chk("clr_pix", outs(), ev(3'b000, 8'(k % 160), 7'(k / 160), 3'd0, 1'b1, 1'b1, 1'b0));
      plots += int'(plot);
      tick();
    end
    chk("clr_done", outs(), ev(3'b000, 8'd0, 7'd0, 3'd0, 1'b0, 1'b0, 1'b1));
    tick();
    chk("clr_done_pulse", 32'({clear_done, clear_busy, plot}), 32'd0);
    chk("clr_plot_count", 32'(plots), 32'd19200);
    req = 3'b111;
    serve(0);
    serve(1);
    serve(2);
    serve(0);
    req = 3'b000;
    tick();
    req = 3'b011;
    tick();
    chk("c1_gnt", 32'(gnt), 32'b010);
    c_x = '0; c_y = '0; c_colour = '0;
    c_plot = 3'b010;
    c_x[15:8] = 8'd30; c_y[13:7] = 7'd40; c_colour[5:3] = 3'd3;
    tick();
    chk("c1_pix0", outs(), ev(3'b010, 8'd30, 7'd40, 3'd3, 1'b1, 1'b0, 1'b0));
    c_x[15:8] = 8'd31; c_y[13:7] = 7'd41; c_colour[5:3] = 3'd4;
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    chk("c1_pix1_noprempt", outs(), ev(3'b010, 8'd31, 7'd41, 3'd4, 1'b1, 1'b0, 1'b0));
    c_x[15:8] = 8'd32; c_y[13:7] = 7'd42; c_colour[5:3] = 3'd5;
    tick();
    chk("c1_pix2", outs(), ev(3'b010, 8'd32, 7'd42, 3'd5, 1'b1, 1'b0, 1'b0));
    c_plot = '0;
    c_done = 3'b010;
    req = 3'b001;
    tick();
    c_done = '0;
    chk("c1_rel", 32'({gnt, plot, clear_busy}), 32'd0);
    tick();
    chk("pend_clr_start", outs(), ev(3'b000, 8'd0, 7'd0, 3'd0, 1'b1, 1'b1, 1'b0));
    repeat (19199) tick();
    chk("pend_clr_last", outs(), ev(3'b000, 8'd159, 7'd119, 3'd0, 1'b1, 1'b1, 1'b0));
    tick();
    chk("pend_clr_done", outs(), ev(3'b000, 8'd0, 7'd0, 3'd0, 1'b0, 1'b0, 1'b1));
    tick();
    chk("c0_after_clr", 32'(gnt), 32'b001);
    req = 3'b000;
    tick();
    chk("c0_drop", 32'(gnt), 32'd0);
    req = 3'b100;
    tick();
    chk("c2_gnt", 32'(gnt), 32'b100);
    c_plot = 3'b100;
    c_x[23:16] = 8'd160; c_y[20:14] = 7'd5; c_colour[8:6] = 3'd7;
    tick();
    chk("clip_x", 32'({gnt, plot}), 32'b1000);
    c_x[23:16] = 8'd10; c_y[20:14] = 7'd120; c_colour[8:6] = 3'd6;
    tick();
    chk("clip_y", 32'({gnt, plot}), 32'b1000);
    c_x[23:16] = 8'd159; c_y[20:14] = 7'd119; c_colour[8:6] = 3'd5;
    tick();
    chk("edge_pix", outs(), ev(3'b100, 8'd159, 7'd119, 3'd5, 1'b1, 1'b0, 1'b0));
    c_plot = '0;
    c_done = 3'b100;
    tick();
    c_done = '0;
    req = 3'b000;
    chk("c2_rel", 32'({gnt, plot}), 32'd0);
    req = 3'b001;
    tick();
    chk("drop_gnt", 32'(gnt), 32'b001);
    req = 3'b000;
    tick();
    chk("drop_rel", 32'({gnt, plot}), 32'd0);
    req = 3'b011;
    tick();
    chk("after_drop_rr", 32'(gnt), 32'b010);
    req = 3'b000;
    tick();
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    chk("rst_clr_start", outs(), ev(3'b000, 8'd0, 7'd0, 3'd0, 1'b1, 1'b1, 1'b0));
    repeat (4850) tick();
    chk("rst_clr_at", outs(), ev(3'b000, 8'd50, 7'd30, 3'd0, 1'b1, 1'b1, 1'b0));
    reset = 1'b1;
    tick();
    chk("mid_reset_outs", outs(), 32'd0);
    reset = 1'b0;
    req = 3'b111;
    tick();
    chk("post_reset_rr", 32'(gnt), 32'b001);
    req = 3'b000;
    tick();
    tick();
    chk("no_stale_clear", 32'({gnt, plot, clear_busy}), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
